systolic_array_scheduler: RTL and testbench

SYSTOLIC_ARRAY_SCHEDULER -- requirements
Module: systolic_array_scheduler

---
 rtl/tc_sched_pkg.sv | 21 ++
 rtl/systolic_array_scheduler_rr_arbiter.sv | 37 +++
 rtl/systolic_array_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_systolic_array_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tc_sched_pkg.sv
// Shared definitions for the tensor-core systolic array scheduler.
//   sched_state_e   : scheduler FSM states
//   TERMINAL_STEP   : push-unit step at which a 4x4 matmul is complete
//   DEF_DATA_STEPS  : default number of operand-consuming push steps
//   DEF_DRAIN_ROWS  : default number of result rows drained per matmul
package tc_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_ACK
  } sched_state_e;

  localparam int unsigned TERMINAL_STEP  = 10;
  localparam int unsigned STEP_W         = 4;
  localparam int unsigned DEF_DATA_STEPS = 7;
  localparam int unsigned DEF_DRAIN_ROWS = 4;

endpackage

// File: rtl/systolic_array_scheduler_rr_arbiter.sv
// Round-robin arbiter (module rr_arbiter) for the systolic array scheduler.
// The search starts at ptr and wraps from NUM_WARPS-1 back to 0.
// Ports:
//   req       : per-warp request vector
//   ptr       : highest-priority warp index for this arbitration
//   gnt       : one-hot winner (all zero when req is zero)
//   gnt_id    : binary index of the winner
//   gnt_valid : a winner exists
module rr_arbiter #(
  parameter int unsigned NUM_WARPS = 4,
  localparam int unsigned IDW      = $clog2(NUM_WARPS)
) (
  input  logic [NUM_WARPS-1:0] req,
  input  logic [IDW-1:0]       ptr,
  output logic [NUM_WARPS-1:0] gnt,
  output logic [IDW-1:0]       gnt_id,
  output logic                 gnt_valid
);

  logic [IDW-1:0] sel;

  always_comb begin
    gnt       = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    sel       = '0;
    for (int unsigned off = 0; off < NUM_WARPS; off++) begin
      sel = IDW'((32'(ptr) + off) % NUM_WARPS);
      if (!gnt_valid && req[sel]) begin
        gnt_valid = 1'b1;
        gnt[sel]  = 1'b1;
        gnt_id    = sel;
      end
    end
  end

endmodule

// File: rtl/systolic_array_scheduler.sv
// Systolic array scheduler: arbitrates warps for a shared 4x4 systolic array,
// sequences clear / run / drain / ack for each matmul.
// Optional feature macro: SCHED_PERF_CNT_EN adds perf_busy_cycles/perf_ops.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   req              : per-warp level requests
//   operand_valid    : owner's operands are valid this cycle
//   matmul_done      : push unit reached its terminal step
//   result_ready     : writeback accepts the offered drain row
//   grant, grant_id  : one-hot / binary owner of the array
//   array_clear      : one-cycle clear of push counter and accumulators
//   array_pause      : freezes push unit and array
//   drain_valid      : a result row is offered
//   drain_row        : index of the offered row
//   ack              : one-cycle completion pulse to the owner
//   busy             : scheduler not idle
//   perf_busy_cycles : (SCHED_PERF_CNT_EN) cycles with busy high, wrapping
//   perf_ops         : (SCHED_PERF_CNT_EN) ack pulses issued, wrapping
module systolic_array_scheduler
  import tc_sched_pkg::*;
#(
  parameter int unsigned NUM_WARPS  = 4,
  parameter int unsigned DATA_STEPS = tc_sched_pkg::DEF_DATA_STEPS,
  parameter int unsigned DRAIN_ROWS = tc_sched_pkg::DEF_DRAIN_ROWS,
  localparam int unsigned IDW       = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_WARPS-1:0] req,
  input  logic                 operand_valid,
  input  logic                 matmul_done,
  input  logic                 result_ready,
  output logic [NUM_WARPS-1:0] grant,
  output logic [IDW-1:0]       grant_id,
  output logic                 array_clear,
  output logic                 array_pause,
  output logic                 drain_valid,
  output logic [1:0]           drain_row,
  output logic [NUM_WARPS-1:0] ack,
  output logic                 busy
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]          perf_busy_cycles,
  output logic [15:0]          perf_ops
`endif
);

  sched_state_e         state_q, state_d;
  logic [NUM_WARPS-1:0] grant_q, grant_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [1:0]           drain_row_q, drain_row_d;

  logic [NUM_WARPS-1:0] arb_gnt;
  logic [IDW-1:0]       arb_id;
  logic                 arb_valid;
  logic                 run_stall;

  rr_arbiter #(
    .NUM_WARPS(NUM_WARPS)
  ) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .gnt      (arb_gnt),
    .gnt_id   (arb_id),
    .gnt_valid(arb_valid)
  );

  // Operands are only needed for the first DATA_STEPS push steps; later
  // steps just propagate partial sums and never wait on the register file.
  assign run_stall = (32'(step_q) < DATA_STEPS) && !operand_valid;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    ptr_d       = ptr_q;
    step_d      = step_q;
    drain_row_d = drain_row_q;
    array_clear = 1'b0;
    array_pause = 1'b1;
    drain_valid = 1'b0;
    ack         = '0;
    busy        = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (arb_valid) begin
          grant_d    = arb_gnt;
          grant_id_d = arb_id;
          state_d    = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        array_clear = 1'b1;
        step_d      = '0;
        drain_row_d = '0;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        array_pause = run_stall;
        if (!run_stall && step_q != STEP_W'(TERMINAL_STEP)) begin
          step_d = step_q + STEP_W'(1);
        end
        if (matmul_done) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_valid = 1'b1;
        if (result_ready) begin
          if (drain_row_q == 2'(DRAIN_ROWS - 1)) begin
            drain_row_d = '0;
            state_d     = ST_ACK;
          end else begin
            drain_row_d = drain_row_q + 2'd1;
          end
        end
      end
      ST_ACK: begin
        ack        = grant_q;
        grant_d    = '0;
        grant_id_d = '0;
        // The finished owner becomes lowest priority next time round.
        ptr_d      = IDW'((32'(grant_id_q) + 32'd1) % NUM_WARPS);
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_id_q  <= '0;
      ptr_q       <= '0;
      step_q      <= '0;
      drain_row_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      ptr_q       <= ptr_d;
      step_q      <= step_d;
      drain_row_q <= drain_row_d;
    end
  end

  assign grant     = grant_q;
  assign grant_id  = grant_id_q;
  assign drain_row = drain_row_q;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [15:0] perf_ops_q, perf_ops_d;

  always_comb begin
    perf_busy_d = perf_busy_q + 32'(busy);
    perf_ops_d  = perf_ops_q + 16'(|ack);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_busy_q <= '0;
      perf_ops_q  <= '0;
    end else begin
      perf_busy_q <= perf_busy_d;
      perf_ops_q  <= perf_ops_d;
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_ops         = perf_ops_q;
`endif

endmodule

// File: tb/tb_systolic_array_scheduler.sv
// Self-checking bench for systolic_array_scheduler. A small push-unit model
// produces matmul_done; expected grants, latencies and pauses come from a
// transaction-level model of the arbitration and timing rules.
module tb_systolic_array_scheduler;

  localparam int NW  = 4;
  localparam int DS  = 7;
  localparam int DR  = 4;
  localparam int IDW = $clog2(NW);
  // Stall-free op: CLEAR + RUN over steps 0..10 + one cycle per row + ACK.
  localparam int LAT0 = 1 + 11 + DR + 1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [NW-1:0]  req;
  logic           operand_valid;
  logic           matmul_done;
  logic           result_ready;
  logic [NW-1:0]  grant;
  logic [IDW-1:0] grant_id;
  logic           array_clear;
  logic           array_pause;
  logic           drain_valid;
  logic [1:0]     drain_row;
  logic [NW-1:0]  ack;
  logic           busy;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0]    perf_busy_cycles;
  logic [15:0]    perf_ops;
`endif

  int checks = 0;
  int errors = 0;
  int ptr    = 0;
  logic [3:0] pcnt;

  systolic_array_scheduler #(
    .NUM_WARPS (NW),
    .DATA_STEPS(DS),
    .DRAIN_ROWS(DR)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .operand_valid(operand_valid),
    .matmul_done  (matmul_done),
    .result_ready (result_ready),
    .grant        (grant),
    .grant_id     (grant_id),
    .array_clear  (array_clear),
    .array_pause  (array_pause),
    .drain_valid  (drain_valid),
    .drain_row    (drain_row),
    .ack          (ack),
    .busy         (busy)
`ifdef SCHED_PERF_CNT_EN
    ,
    .perf_busy_cycles(perf_busy_cycles),
    .perf_ops        (perf_ops)
`endif
  );

  always #5 clk = ~clk;

  // Push unit: step counter cleared by array_clear, frozen by array_pause.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pcnt <= 4'd0;
    else if (array_clear) pcnt <= 4'd0;
    else if (!array_pause && pcnt != 4'd10) pcnt <= pcnt + 4'd1;
  end
  assign matmul_done = (pcnt == 4'd10);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NW-1:0] r, input int p);
    for (int k = 0; k < NW; k++) begin
      int j;
      j = (p + k) % NW;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk_reset_values();
    chk("rst_grant", grant, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_ack", ack, 0);
    chk("rst_drain_valid", drain_valid, 0);
    chk("rst_drain_row", drain_row, 0);
    chk("rst_array_clear", array_clear, 0);
    chk("rst_busy", busy, 0);
    chk("rst_array_pause", array_pause, 1);
  endtask

  // One operation. sp/sl: operand_valid low for sl cycles from push step sp.
  // dr/dl: result_ready low for dl cycles while row dr is offered.
  // nreq: request vector applied mid-operation.
  task automatic run_op(input int sp, input int sl, input int dr, input int dl,
                        input logic [NW-1:0] nreq);
    int w, cyc, clr, acks, ack_at, left, dleft, extra;
    bit sstart, dstart;
    logic [NW-1:0] eg;
    w      = rr_pick(req, ptr);
    eg     = NW'(1) << w;
    extra  = ((sp < DS) ? sl : 0) + dl;
    cyc    = 0;
    while (grant == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("grant", grant, eg);
    chk("grant_id", grant_id, w);
    chk("busy", busy, 1);
    cyc = 0; clr = 0; acks = 0; ack_at = 0;
    left = sl; dleft = dl; sstart = 0; dstart = 0;
    while (grant != '0 && cyc < 200) begin
      cyc++;
      if (cyc == 5) req = nreq;
      operand_valid = 1'b1;
      if (!sstart && pcnt == sp) sstart = 1;
      if (sstart && left > 0) begin
        operand_valid = 1'b0;
        left--;
      end
      result_ready = 1'b1;
      if (!dstart && drain_valid && drain_row == dr) dstart = 1;
      if (dstart && dleft > 0) begin
        result_ready = 1'b0;
        dleft--;
      end
      #1;
      if (!operand_valid) chk("pause", array_pause, (sp < DS) ? 1 : 0);
      if (!result_ready) chk("drain_hold", drain_row, dr);
      if (array_clear) clr++;
      if (ack != '0) begin
        acks++;
        ack_at = cyc;
        chk("ack", ack, eg);
      end
      @(negedge clk);
    end
    operand_valid = 1'b1;
    result_ready  = 1'b1;
    chk("op_done", (grant == '0), 1);
    chk("ack_count", acks, 1);
    chk("latency", ack_at, LAT0 + extra);
    chk("clear_pulses", clr, 1);
    chk("idle_busy", busy, 0);
    ptr = (w + 1) % NW;
  endtask

  initial begin
    int cyc, saw_ack, sp, sl, dr, dl;
    logic [NW-1:0] nr;
    reset_n = 1'b0;
    req = '0;
    operand_valid = 1'b1;
    result_ready = 1'b1;
    #2;
    chk_reset_values();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Stall-free op, then the same requests again: warp 0 then warp 2.
    req = 4'b0101;
    run_op(3, 0, 0, 0, 4'b0101);
    run_op(3, 2, 0, 0, 4'b0101);

    // Reset during DRAIN: abandoned op, pointer returns to 0.
    req = 4'b0100;
    cyc = 0; saw_ack = 0;
    while (!drain_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) saw_ack++;
    end
    chk("drain_reached", drain_valid, 1);
    chk("abort_owner", grant, 4'b0100);
    reset_n = 1'b0;
    req = 4'b1010;
    #1;
    chk_reset_values();
    repeat (2) begin
      @(negedge clk);
      if (ack != '0) saw_ack++;
    end
    reset_n = 1'b1;
    ptr = 0;
    chk("no_ack_on_abort", saw_ack, 0);

    // Two back-to-back stall-free ops after reset.
    run_op(3, 0, 0, 0, 4'b1010);
    run_op(3, 0, 0, 0, 4'b1010);
`ifdef SCHED_PERF_CNT_EN
    chk("perf_ops", perf_ops, 2);
    chk("perf_busy_cycles", perf_busy_cycles, 2 * LAT0);
`endif

    // Late operand gap (no pause) and a drain stall on row 2.
    run_op(8, 2, 2, 3, 4'b1010);

    for (int i = 0; i < 12; i++) begin
      sp = $urandom_range(1, 8);
      sl = $urandom_range(0, 3);
      if (sp >= DS && sl > 10 - sp) sl = 10 - sp;
      dr = $urandom_range(0, DR - 1);
      dl = $urandom_range(0, 3);
      nr = NW'($urandom_range(1, (1 << NW) - 1));
      run_op(sp, sl, dr, dl, nr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
